alu_sweep_checker: RTL

Hardware exhaustive-sweep stimulus generator and response checker for the team's combinational ALU slices (and_gate and its siblings). On a start request it drives every operand pair (A, B) into a slice, waits a configurable settle time, compares the slice output against an internal golden model for the selected operation, and reports an error count and pass/fail. It brings the sweep-and-check loop from the simulation benches into synthesizable logic for on-chip self-test of the ALU.

---
 rtl/alu_sweep_checker.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/alu_sweep_checker.sv
// alu_sweep_checker: on-chip exhaustive self-test for a combinational ALU slice.
// Walks every (A, B) operand pair, lets the slice settle, and compares y against
// a golden AND/OR/XOR/NAND model. It reports a mismatch count and pass/fail.
// Optional feature macro: ALU_SWEEP_FIRST_FAIL_EN adds fail_a_o/fail_b_o/fail_y_o,
// which capture the first failing vector of a sweep.
module alu_sweep_checker #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [1:0]         op_i,
  output logic [WIDTH-1:0]   a_o,
  output logic [WIDTH-1:0]   b_o,
  input  logic [WIDTH-1:0]   y_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               pass_o,
  output logic [2*WIDTH:0]   err_count_o
`ifdef ALU_SWEEP_FIRST_FAIL_EN
  ,
  output logic [WIDTH-1:0]   fail_a_o,
  output logic [WIDTH-1:0]   fail_b_o,
  output logic [WIDTH-1:0]   fail_y_o
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);
  localparam int EW = 2*WIDTH + 1;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [EW-1:0]    err_q, err_d;
`ifdef ALU_SWEEP_FIRST_FAIL_EN
  logic [WIDTH-1:0] failA_q, failA_d;
  logic [WIDTH-1:0] failB_q, failB_d;
  logic [WIDTH-1:0] failY_q, failY_d;
`endif

  logic [WIDTH-1:0] golden;
  logic             mismatch;
  logic             lastVec;

  // Expected slice output for the op latched at start
  always_comb begin
    golden = '0;
    case (op_q)
      2'b00:   golden = a_q & b_q;
      2'b01:   golden = a_q | b_q;
      2'b10:   golden = a_q ^ b_q;
      default: golden = ~(a_q & b_q);
    endcase
  end

  assign mismatch = (y_i != golden);
  assign lastVec  = &{a_q, b_q};

  // Sweep sequencing: accept start, settle, check, advance b (inner) then a
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
`ifdef ALU_SWEEP_FIRST_FAIL_EN
    failA_d = failA_q;
    failB_d = failB_q;
    failY_d = failY_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          op_d    = op_i;
          a_d     = '0;
          b_d     = '0;
          cnt_d   = '0;
          err_d   = '0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
`ifdef ALU_SWEEP_FIRST_FAIL_EN
          failA_d = '0;
          failB_d = '0;
          failY_d = '0;
`endif
          state_d = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_CHECK: begin
        if (mismatch) begin
          err_d = err_q + EW'(1);
`ifdef ALU_SWEEP_FIRST_FAIL_EN
          if (err_q == '0) begin
            failA_d = a_q;
            failB_d = b_q;
            failY_d = y_i;
          end
`endif
        end
        if (lastVec) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          pass_d  = (err_d == '0);
          state_d = S_DONE;
        end else begin
          {a_d, b_d} = {a_q, b_q} + (2*WIDTH)'(1);
          state_d    = S_DRIVE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers, cleared immediately by reset so a sweep can be abandoned
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
`ifdef ALU_SWEEP_FIRST_FAIL_EN
      failA_q <= '0;
      failB_q <= '0;
      failY_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
`ifdef ALU_SWEEP_FIRST_FAIL_EN
      failA_q <= failA_d;
      failB_q <= failB_d;
      failY_q <= failY_d;
`endif
    end
  end

  assign a_o         = a_q;
  assign b_o         = b_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign err_count_o = err_q;
`ifdef ALU_SWEEP_FIRST_FAIL_EN
  assign fail_a_o = failA_q;
  assign fail_b_o = failB_q;
  assign fail_y_o = failY_q;
`endif

endmodule
